// File: rtl/ddc_reconfig_ctrl_pkg.sv
// Shared types and constants for the DDC reconfiguration controller:
// FSM state encoding, bypass-flag bit positions and word byte counts.
package ddc_reconfig_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FREQ,
    S_GAP1,
    S_WR_RATE,
    S_GAP2,
    S_APPLY,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int FLAG_CORDIC     = 0;
  localparam int FLAG_CIC        = 1;
  localparam int FLAG_CIC_STROBE = 2;
  localparam int FLAG_HBF        = 3;

  localparam logic [2:0] FREQ_BYTES = 3'd4;
  localparam logic [2:0] RATE_BYTES = 3'd2;

endpackage

// File: rtl/rbus_word_writer.sv
// Serialises an up-to-4-byte word onto the register bus, LSB first.
// Ports: start_i/nbytes_i/word_i load a word; busy_o, last_o, byte_o.
module rbus_word_writer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  nbytes_i,
  input  logic [31:0] word_i,
  output logic        busy_o,
  output logic        last_o,
  output logic [7:0]  byte_o
);

  logic [31:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;

  assign busy_o = (cnt_q != 3'd0);
  assign last_o = (cnt_q == 3'd1);
  assign byte_o = sh_q[7:0];

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sh_d  = word_i;
      cnt_d = nbytes_i;
    end else if (busy_o) begin
      sh_d  = {8'h00, sh_q[31:8]};
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddc_reconfig_ctrl.sv
// Sequences a DDC reconfiguration: writes phase increment and decimation
// words over the byte register bus, applies bypass flags, then masks a
// programmable number of DDC output strobes before reporting done.
// Ports: cfg_* request side, rbus_* register bus, ddc_* DDC side.
module ddc_reconfig_ctrl
  import ddc_reconfig_ctrl_pkg::*;
#(
  parameter logic [7:0] IF_FREQ_ADDR    = 8'd0,
  parameter logic [7:0] DECIM_RATE_ADDR = 8'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_req,
  input  logic [31:0] cfg_freq,
  input  logic [12:0] cfg_decim,
  input  logic [3:0]  cfg_flags,
  input  logic [7:0]  cfg_flush,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  rbus_addr,
  output logic [7:0]  rbus_data,
  output logic        rbus_we,
  output logic        rbus_strobe,
  output logic [3:0]  ddc_cfgflags,
  input  logic        ddc_strobe_in,
  output logic        out_strobe
);

  state_e      state_q, state_d;
  logic [12:0] decim_q, decim_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  flush_q, flush_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  cfgfl_q, cfgfl_d;
  logic        err_q, err_d;

  logic        wr_start;
  logic [2:0]  wr_n;
  logic [31:0] wr_word;
  logic        wr_busy;
  logic        wr_last;
  logic [7:0]  wr_byte;

  rbus_word_writer u_wr (
    .clock    (clock),
    .reset    (reset),
    .start_i  (wr_start),
    .nbytes_i (wr_n),
    .word_i   (wr_word),
    .busy_o   (wr_busy),
    .last_o   (wr_last),
    .byte_o   (wr_byte)
  );

  always_comb begin
    state_d  = state_q;
    decim_d  = decim_q;
    flags_d  = flags_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    cfgfl_d  = cfgfl_q;
    err_d    = cfg_req && (state_q != S_IDLE);
    wr_start = 1'b0;
    wr_n     = FREQ_BYTES;
    wr_word  = cfg_freq;
    cfg_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          decim_d  = cfg_decim;
          flags_d  = cfg_flags;
          flush_d  = cfg_flush;
          addr_d   = IF_FREQ_ADDR;
          wr_start = 1'b1;
          state_d  = S_WR_FREQ;
        end
      end
      S_WR_FREQ: if (wr_last) state_d = S_GAP1;
      S_GAP1: begin
        wr_start = 1'b1;
        wr_n     = RATE_BYTES;
        wr_word  = {19'h0, decim_q};
        addr_d   = DECIM_RATE_ADDR;
        state_d  = S_WR_RATE;
      end
      S_WR_RATE: if (wr_last) state_d = S_GAP2;
      S_GAP2: state_d = S_APPLY;
      S_APPLY: begin
        cfgfl_d[FLAG_CORDIC]     = flags_q[FLAG_CORDIC];
        cfgfl_d[FLAG_CIC]        = flags_q[FLAG_CIC];
        cfgfl_d[FLAG_CIC_STROBE] = flags_q[FLAG_CIC_STROBE];
        cfgfl_d[FLAG_HBF]        = flags_q[FLAG_HBF];
        cnt_d   = flush_q;
        state_d = (flush_q != 8'd0) ? S_FLUSH : S_DONE;
      end
      S_FLUSH: begin
        if (ddc_strobe_in) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        cfg_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      decim_q <= '0;
      flags_q <= '0;
      flush_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      cfgfl_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cfgfl_q <= cfgfl_d;
      err_q   <= err_d;
    end
  end

  assign cfg_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cfg_err      = err_q;
  assign rbus_addr    = addr_q;
  assign rbus_we      = wr_busy;
  assign rbus_strobe  = wr_busy;
  assign rbus_data    = wr_busy ? wr_byte : 8'h00;
  assign ddc_cfgflags = cfgfl_q;
  // strobes pass only while idle; everything during a reconfig is junk
  assign out_strobe   = ddc_strobe_in && (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_ddc_reconfig_ctrl.sv
// Scoreboard bench for ddc_reconfig_ctrl: directed cases plus randomized
// requests, expected events queued by stimulus and checked by a monitor.
module tb_ddc_reconfig_ctrl;

  localparam logic [7:0] A_FREQ = 8'd0;
  localparam logic [7:0] A_RATE = 8'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_req = 1'b0;
  logic [31:0] cfg_freq = '0;
  logic [12:0] cfg_decim = '0;
  logic [3:0]  cfg_flags = '0;
  logic [7:0]  cfg_flush = '0;
  logic        ddc_strobe_in = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  rbus_addr, rbus_data;
  logic        rbus_we, rbus_strobe, out_strobe;
  logic [3:0]  ddc_cfgflags;

  ddc_reconfig_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_req       (cfg_req),
    .cfg_freq      (cfg_freq),
    .cfg_decim     (cfg_decim),
    .cfg_flags     (cfg_flags),
    .cfg_flush     (cfg_flush),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .rbus_addr     (rbus_addr),
    .rbus_data     (rbus_data),
    .rbus_we       (rbus_we),
    .rbus_strobe   (rbus_strobe),
    .ddc_cfgflags  (ddc_cfgflags),
    .ddc_strobe_in (ddc_strobe_in),
    .out_strobe    (out_strobe)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int         c;
    logic [3:0] f;
  } done_t;

  typedef struct {
    int         c;
    logic       busy;
    logic       ostb;
    logic [3:0] flags;
    logic       achk;
    logic [7:0] addr;
  } cyc_t;

  wr_t   wq[$];
  done_t dq[$];
  int    eq[$];
  cyc_t  cq[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] cur_flags = 4'h0;
  logic [7:0] cur_addr  = 8'h00;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic extra(string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected pulse cycle %0d", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clock) begin
    cyc_t  r;
    wr_t   w;
    done_t d;
    int    e;
    if (cq.size() > 0) begin
      r = cq.pop_front();
      chk("cyc_align", cyc, r.c);
      chk("busy", cfg_busy, r.busy);
      chk("out_strobe", out_strobe, r.ostb);
      chk("cfgflags", ddc_cfgflags, r.flags);
      if (r.achk) chk("idle_addr", rbus_addr, r.addr);
    end
    chk("we_eq_strobe", rbus_we, rbus_strobe);
    if (!rbus_strobe) chk("data_idle", rbus_data, 8'h00);
    if (rbus_strobe) begin
      if (wq.size() == 0) extra("bus_write");
      else begin
        w = wq.pop_front();
        chk("wr_cyc", cyc, w.c);
        chk("wr_addr", rbus_addr, w.a);
        chk("wr_data", rbus_data, w.d);
      end
    end
    if (cfg_done) begin
      if (dq.size() == 0) extra("cfg_done");
      else begin
        d = dq.pop_front();
        chk("done_cyc", cyc, d.c);
        chk("done_flags", ddc_cfgflags, d.f);
      end
    end
    if (cfg_err) begin
      if (eq.size() == 0) extra("cfg_err");
      else begin
        e = eq.pop_front();
        chk("err_cyc", cyc, e);
      end
    end
  end

  task automatic step(logic req, logic [31:0] f, logic [12:0] d,
                      logic [3:0] fl, logic [7:0] fs, logic stb,
                      logic rst, cyc_t r);
    @(posedge clock);
    #1;
    cfg_req       = req;
    cfg_freq      = f;
    cfg_decim     = d;
    cfg_flags     = fl;
    cfg_flush     = fs;
    ddc_strobe_in = stb;
    reset         = rst;
    r.c           = cyc;
    cq.push_back(r);
  endtask

  // mode: 0 random strobes, 1 every 4 from T+10, 2 at T and T+1, 3 none
  task automatic run_txn(logic [31:0] f, logic [12:0] d, logic [3:0] fl,
                         logic [7:0] fs, int mode, int err_off,
                         int rst_off);
    bit   stb[0:511];
    int   done_off;
    int   end_off;
    int   k;
    int   t;
    wr_t  w;
    done_t dn;
    cyc_t r;
    logic req;
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: stb[i] = (i >= 300) || ($urandom_range(0, 2) == 0);
        1: stb[i] = (i >= 10) && ((i - 10) % 4 == 0);
        2: stb[i] = (i <= 1);
        default: stb[i] = 1'b0;
      endcase
    end
    done_off = 10;
    if (fs != 0) begin
      k = 0;
      for (int i = 10; i < 512; i++) begin
        if (stb[i]) begin
          k++;
          if (k == int'(fs)) begin
            done_off = i + 1;
            break;
          end
        end
      end
    end
    if (err_off == -2) err_off = $urandom_range(1, done_off);
    end_off = (rst_off >= 0) ? rst_off : done_off;
    t = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      w.c = t + 1 + i; w.a = A_FREQ; w.d = f[8*i +: 8];
      if (1 + i <= end_off) wq.push_back(w);
    end
    w.c = t + 6; w.a = A_RATE; w.d = d[7:0];
    if (6 <= end_off) wq.push_back(w);
    w.c = t + 7; w.a = A_RATE; w.d = {3'b000, d[12:8]};
    if (7 <= end_off) wq.push_back(w);
    if (rst_off < 0) begin
      dn.c = t + done_off; dn.f = fl;
      dq.push_back(dn);
    end
    if (err_off >= 0) eq.push_back(t + err_off + 1);
    for (int off = 0; off <= end_off; off++) begin
      req    = (off == 0) || (off == err_off);
      r.busy = (off >= 1) && (off < done_off);
      r.ostb = (off == 0) ? stb[0] : 1'b0;
      r.flags = (off >= 10) ? fl : cur_flags;
      r.achk = 1'b0;
      r.addr = 8'h00;
      if (off == 0)
        step(req, f, d, fl, fs, stb[off], 1'b0, r);
      else
        step(req, $urandom, 13'($urandom), 4'($urandom),
             8'($urandom), stb[off], (off == rst_off), r);
    end
    cur_flags = (rst_off >= 0) ? 4'h0 : fl;
    cur_addr  = (rst_off >= 0) ? 8'h00 : A_RATE;
    for (int off = end_off + 1; off <= end_off + 4; off++) begin
      r.busy  = 1'b0;
      r.ostb  = stb[off];
      r.flags = cur_flags;
      r.achk  = 1'b1;
      r.addr  = cur_addr;
      step(1'b0, '0, '0, '0, '0, stb[off], 1'b0, r);
    end
  endtask

  initial begin
    cyc_t r;
    r.busy = 1'b0; r.ostb = 1'b0; r.flags = 4'h0;
    r.achk = 1'b1; r.addr = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, r);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, r);

    run_txn(32'h12345678, 13'h0104, 4'h0, 8'd0, 3, -1, -1);
    run_txn(32'hCAFEF00D, 13'h1ABC, 4'h5, 8'd0, 2, -1, -1);
    run_txn(32'h0BADBEEF, 13'h0033, 4'h2, 8'd3, 1, -1, -1);
    run_txn(32'h12345678, 13'h0104, 4'h0, 8'd0, 3, 3, -1);
    run_txn(32'h87654321, 13'h1FFF, 4'hF, 8'd0, 3, -1, -1);
    run_txn(32'hA5A5A5A5, 13'h0AAA, 4'h9, 8'd0, 3, 10, -1);
    run_txn(32'h11223344, 13'h0555, 4'h6, 8'd2, 3, -1, 6);
    run_txn(32'h55667788, 13'h0101, 4'h3, 8'd0, 3, -1, -1);

    for (int n = 0; n < 25; n++) begin
      run_txn($urandom, 13'($urandom), 4'($urandom),
              8'($urandom_range(0, 6)), 0,
              ($urandom_range(0, 1) == 1) ? -2 : -1, -1);
    end

    repeat (3) @(posedge clock);
    #1;
    chk("wq_left", wq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("eq_left", eq.size(), 0);
    chk("cq_left", cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
